// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Drives one shared BCD decoder per slot, with a blanking guard and tear-free frame-boundary loads.
module seg7_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  lz_blank_i,
    input  logic                  load_i,
    output logic                  load_ack_o,
    output logic [3:0]            bcd_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      slot_cnt;
    logic [CNT_W-1:0]      slot_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [4*N_DIGITS-1:0] shadow_val;
    logic [4*N_DIGITS-1:0] val_nxt;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   dp_nxt;
    logic                  slot_wrap;
    logic                  frame_edge;
    logic                  capture;
    logic                  lead;
    logic [N_DIGITS-1:0]   suppress;
    logic [3:0]            bcd_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
    logic                  dp_seg_nxt;

    // Outputs are computed from the post-edge slot/digit so they line up with the registered scan state;
    // a load captured on the frame edge is bypassed straight into digit 0.
    always_comb begin
        slot_wrap  = (slot_cnt == SLOT_LAST);
        frame_edge = slot_wrap && (idx == IDX_LAST);
        capture    = frame_edge && load_i;
        slot_nxt   = slot_wrap ? '0 : slot_cnt + CNT_W'(1);

        if (!slot_wrap)
            idx_nxt = idx;
        else if (idx == IDX_LAST)
            idx_nxt = '0;
        else
            idx_nxt = idx + IDX_W'(1);

        if (slot_wrap)
            state_nxt = BLANK;
        else if (state == BLANK && slot_cnt == BLANK_LAST)
            state_nxt = SHOW;
        else
            state_nxt = state;

        val_nxt = capture ? value_i : shadow_val;
        dp_nxt  = capture ? dp_i : shadow_dp;

        // A digit stays dark while it and everything above it is a plain zero without a decimal point.
        lead     = lz_blank_i;
        suppress = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            lead        = lead && (val_nxt[4*k +: 4] == 4'h0) && !dp_nxt[k];
            suppress[k] = lead;
        end

        bcd_nxt    = '0;
        an_nxt     = '1;
        dp_seg_nxt = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                bcd_nxt = val_nxt[4*k +: 4];
                if (state_nxt == SHOW && !suppress[k]) begin
                    an_nxt[k]  = 1'b0;
                    dp_seg_nxt = ~dp_nxt[k];
                end
            end
        end
    end

    // Scan state, shadow registers and all pin-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            slot_cnt   <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            bcd_o      <= '0;
            an_o       <= '1;
            dp_o       <= 1'b1;
            load_ack_o <= 1'b0;
            frame_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot_cnt   <= slot_nxt;
            idx        <= idx_nxt;
            shadow_val <= val_nxt;
            shadow_dp  <= dp_nxt;
            bcd_o      <= bcd_nxt;
            an_o       <= an_nxt;
            dp_o       <= dp_seg_nxt;
            load_ack_o <= capture;
            frame_o    <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: table-driven display vectors fed through a scoreboard,
// per-cycle scan timing checks, and hand-written reset/handshake sequences.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic          clk;
    logic          rst_n;
    logic [15:0]   value_i;
    logic [3:0]    dp_i;
    logic          lz_blank_i;
    logic          load_i;
    logic          load_ack_o;
    logic [3:0]    bcd_o;
    logic [3:0]    an_o;
    logic          dp_o;
    logic          frame_o;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        logic [15:0] exp_bcd;
        logic [15:0] exp_an;
        logic [3:0]  exp_dp;
    } vec_t;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    vec_t  vecs [8];
    exp_t  sb_q [$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    int    cyc;
    int    mon_slot;
    int    mon_idx;
    logic  exp_frame;
    logic  exp_ack;
    logic  [3:0] prev_bcd;
    logic  [3:0] mon_onehot;

    seg7_scan_ctrl #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value_i),
        .dp_i       (dp_i),
        .lz_blank_i (lz_blank_i),
        .load_i     (load_i),
        .load_ack_o (load_ack_o),
        .bcd_o      (bcd_o),
        .an_o       (an_o),
        .dp_o       (dp_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Cycle count since reset release; frame and ack expectations follow from it and load_i alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc       <= 0;
            exp_frame <= 1'b0;
            exp_ack   <= 1'b0;
        end else begin
            cyc       <= cyc + 1;
            exp_frame <= ((cyc % FRAME) == FRAME - 1);
            exp_ack   <= ((cyc % FRAME) == FRAME - 1) && load_i;
        end
    end

    // Per-cycle scan checks, plus scoreboard pops in the middle of each digit's SHOW window.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bcd = bcd_o;
        end else begin
            mon_slot   = cyc % DIV;
            mon_idx    = (cyc / DIV) % N;
            mon_onehot = ~(4'b0001 << mon_idx);
            checkOutput("frame_o", 16'(frame_o), 16'(exp_frame));
            checkOutput("load_ack_o", 16'(load_ack_o), 16'(exp_ack));
            checkOutput("an_at_most_one_low", 16'($countones(~an_o) <= 1), 16'h1);
            if (mon_slot < BLK) begin
                checkOutput("an_blank", 16'(an_o), 16'hF);
                checkOutput("dp_blank", 16'(dp_o), 16'h1);
            end else if (an_o != 4'hF) begin
                checkOutput("an_digit", 16'(an_o), 16'(mon_onehot));
            end else begin
                checkOutput("dp_dark", 16'(dp_o), 16'h1);
            end
            if (bcd_o !== prev_bcd)
                checkOutput("bcd_change_slot", 16'(mon_slot), 16'h0);
            prev_bcd = bcd_o;
            if (mon_slot == 4 && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_bcd", 16'(bcd_o), 16'(mon_e.bcd));
                checkOutput("sb_an", 16'(an_o), 16'(mon_e.an));
                checkOutput("sb_dp", 16'(dp_o), 16'(mon_e.dp));
            end
        end
    end

    task automatic pushFrame(input int v);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.bcd = vecs[v].exp_bcd[4*k +: 4];
            e.an  = vecs[v].exp_an[4*k +: 4];
            e.dp  = vecs[v].exp_dp[k];
            sb_q.push_back(e);
        end
    endtask

    task automatic waitFrameStart();
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (rst_n && (cyc % FRAME) == 0) break;
        end
    endtask

    task automatic waitCycMod(input int m);
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (rst_n && (cyc % FRAME) == m) break;
        end
    endtask

    task automatic drainQueue();
        for (int n = 0; n < 4 * FRAME; n++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        sb_q.delete();
    endtask

    task automatic applyStimulus(input int v);
        logic got;
        @(negedge clk);
        value_i    = vecs[v].value;
        dp_i       = vecs[v].dp;
        lz_blank_i = vecs[v].lz;
        repeat (5) @(negedge clk);
        load_i = 1'b1;
        got    = 1'b0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (load_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        load_i = 1'b0;
        checkOutput("ack_seen", 16'(got), 16'h1);
        if (got) pushFrame(v);
        drainQueue();
    endtask

    initial begin
        int acks;
        int ack_cyc;

        //            value     dp    lz    bcd       an        dp_o
        vecs[0] = '{16'h1234, 4'h0, 1'b0, 16'h1234, 16'h7BDE, 4'hF};
        vecs[1] = '{16'h0050, 4'h0, 1'b1, 16'h0050, 16'hFFDE, 4'hF};
        vecs[2] = '{16'h0000, 4'h0, 1'b1, 16'h0000, 16'hFFFE, 4'hF};
        vecs[3] = '{16'h0007, 4'h4, 1'b1, 16'h0007, 16'hFBDE, 4'hB};
        vecs[4] = '{16'hA0F0, 4'h0, 1'b1, 16'hA0F0, 16'h7BDE, 4'hF};
        vecs[5] = '{16'h0000, 4'h9, 1'b0, 16'h0000, 16'h7BDE, 4'h6};
        vecs[6] = '{16'h00B0, 4'h0, 1'b1, 16'h00B0, 16'hFFDE, 4'hF};
        vecs[7] = '{16'h0000, 4'h0, 1'b0, 16'h0000, 16'h7BDE, 4'hF};

        rst_n      = 1'b0;
        value_i    = '0;
        dp_i       = '0;
        lz_blank_i = 1'b0;
        load_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_an", 16'(an_o), 16'hF);
        checkOutput("reset_dp", 16'(dp_o), 16'h1);
        checkOutput("reset_bcd", 16'(bcd_o), 16'h0);
        checkOutput("reset_ack", 16'(load_ack_o), 16'h0);
        checkOutput("reset_frame", 16'(frame_o), 16'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] idle scan after reset");
        waitFrameStart();
        pushFrame(7);
        drainQueue();

        $display("[TB] table vectors");
        applyStimulus(0);

        // Producer changes its value without requesting a load: display must keep the old frame.
        @(negedge clk);
        value_i = 16'h9876;
        dp_i    = 4'hF;
        waitFrameStart();
        pushFrame(0);
        drainQueue();

        for (int v = 1; v <= 6; v++) applyStimulus(v);

        $display("[TB] async reset during digit 2 with load pending");
        lz_blank_i = 1'b0;
        dp_i       = 4'h0;
        value_i    = 16'h1234;
        waitCycMod(2 * DIV + 1);
        load_i = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_an", 16'(an_o), 16'hF);
        checkOutput("midreset_bcd", 16'(bcd_o), 16'h0);
        checkOutput("midreset_dp", 16'(dp_o), 16'h1);
        checkOutput("midreset_ack", 16'(load_ack_o), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        acks    = 0;
        ack_cyc = -1;
        for (int n = 0; n < FRAME + 8; n++) begin
            @(negedge clk);
            if (load_ack_o) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = cyc;
                load_i = 1'b0;
                pushFrame(0);
            end
        end
        load_i = 1'b0;
        checkOutput("midreset_ack_count", 16'(acks), 16'h1);
        checkOutput("midreset_ack_cyc", 16'(ack_cyc), 16'(FRAME));
        drainQueue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
